// File: rtl/convolution_procesor_addr_sequencer.sv
// convolution_procesor_addr_sequencer: nested-loop (X,Y,Z) address generator for Z[i] = sum_j X[j]*Y[i-j].
// Revision: 1.0
`default_nettype none

module convolution_procesor_addr_sequencer #(
  parameter int ADDR_WIDTH_X = 5,
  parameter int ADDR_WIDTH_Y = 5,
  parameter int ADDR_WIDTH_Z = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH_X:0]   sizeX_i,
  input  logic [ADDR_WIDTH_Y:0]   sizeY_i,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic [ADDR_WIDTH_X-1:0] addrX_o,
  output logic [ADDR_WIDTH_Y-1:0] addrY_o,
  output logic [ADDR_WIDTH_Z-1:0] addrZ_o,
  output logic                    first_o,
  output logic                    last_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int W = ADDR_WIDTH_Z + 1;
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TWO = W'(2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                    state_q;
  logic [ADDR_WIDTH_X:0]     sx_q;
  logic [ADDR_WIDTH_Y:0]     sy_q;
  logic [W-1:0]              i_q, j_q;
  logic                      valid_q, first_q, last_q;
  logic [ADDR_WIDTH_X-1:0]   addrX_q;
  logic [ADDR_WIDTH_Y-1:0]   addrY_q;
  logic [ADDR_WIDTH_Z-1:0]   addrZ_q;

  logic [W-1:0] sx_w, sy_w, ilast_w;
  logic [W-1:0] i_d, j_d;
  logic         final_d, first_d, last_d;

  // j_lo(i) = max(0, i-sizeY+1), computed without going negative
  function automatic logic [W-1:0] f_jlo(input logic [W-1:0] i, input logic [W-1:0] sy);
    return ((i + ONE) >= sy) ? (i + ONE - sy) : '0;
  endfunction

  // j_hi(i) = min(i, sizeX-1)
  function automatic logic [W-1:0] f_jhi(input logic [W-1:0] i, input logic [W-1:0] sx);
    return ((i + ONE) >= sx) ? (sx - ONE) : i;
  endfunction

  assign sx_w    = W'(sx_q);
  assign sy_w    = W'(sy_q);
  assign ilast_w = sx_w + sy_w - TWO;

  always_comb begin
    final_d = 1'b0;
    i_d     = i_q;
    j_d     = j_q + ONE;
    if (j_q >= f_jhi(i_q, sx_w)) begin
      final_d = (i_q >= ilast_w);
      i_d     = i_q + ONE;
      j_d     = f_jlo(i_q + ONE, sy_w);
    end
    first_d = (j_d == f_jlo(i_d, sy_w));
    last_d  = (j_d >= f_jhi(i_d, sx_w));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      sx_q    <= '0;
      sy_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      addrX_q <= '0;
      addrY_q <= '0;
      addrZ_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            sx_q    <= sizeX_i;
            sy_q    <= sizeY_i;
            i_q     <= '0;
            j_q     <= '0;
            addrX_q <= '0;
            addrY_q <= '0;
            addrZ_q <= '0;
            if (sizeX_i == '0 || sizeY_i == '0) begin
              state_q <= S_DONE;
            end else begin
              // beat (0,0,0) is always both first and last of Z[0]
              state_q <= S_RUN;
              valid_q <= 1'b1;
              first_q <= 1'b1;
              last_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (valid_q && ready_i) begin
            if (final_d) begin
              state_q <= S_DONE;
              valid_q <= 1'b0;
              first_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              i_q     <= i_d;
              j_q     <= j_d;
              addrX_q <= ADDR_WIDTH_X'(j_d);
              addrY_q <= ADDR_WIDTH_Y'(i_d - j_d);
              addrZ_q <= ADDR_WIDTH_Z'(i_d);
              first_q <= first_d;
              last_q  <= last_d;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign valid_o = valid_q;
  assign addrX_o = addrX_q;
  assign addrY_o = addrY_q;
  assign addrZ_o = addrZ_q;
  assign first_o = first_q;
  assign last_o  = last_q;
  assign busy_o  = (state_q != S_IDLE);
  assign done_o  = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_convolution_procesor_addr_sequencer.sv
// tb_convolution_procesor_addr_sequencer: scoreboard bench with a loop-level reference model.
// Revision: 1.0
`default_nettype none

module tb_convolution_procesor_addr_sequencer;

  localparam int AX = 5;
  localparam int AY = 5;
  localparam int AZ = 6;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] z;
    logic       f;
    logic       l;
  } beat_t;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          start_i = 1'b0;
  logic [AX:0]   sizeX_i = '0;
  logic [AY:0]   sizeY_i = '0;
  logic          ready_i = 1'b0;
  logic          valid_o, first_o, last_o, busy_o, done_o;
  logic [AX-1:0] addrX_o;
  logic [AY-1:0] addrY_o;
  logic [AZ-1:0] addrZ_o;

  convolution_procesor_addr_sequencer #(
    .ADDR_WIDTH_X(AX), .ADDR_WIDTH_Y(AY), .ADDR_WIDTH_Z(AZ)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i),
    .sizeX_i(sizeX_i), .sizeY_i(sizeY_i), .ready_i(ready_i),
    .valid_o(valid_o), .addrX_o(addrX_o), .addrY_o(addrY_o), .addrZ_o(addrZ_o),
    .first_o(first_o), .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int    n_vec = 0;
  int    n_err = 0;
  beat_t exp_q[$];
  int    beats_seen = 0;
  int    done_cnt = 0;
  int    last_cnt = 0;
  int    rdy_mode = 0;
  int    phase = 0;
  bit    have_hold = 1'b0;
  beat_t hold, cur, expb;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ready pattern: 0 = always, 1 = 1,0,0 repeating, 2 = random
  initial forever begin
    @(posedge clk_i); #1;
    case (rdy_mode)
      0: ready_i = 1'b1;
      1: begin ready_i = (phase % 3 == 0); phase++; end
      default: ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  // monitor: stall stability, then transfer comparison against the queue
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      have_hold = 1'b0;
    end else begin
      cur.x = 8'(addrX_o); cur.y = 8'(addrY_o); cur.z = 8'(addrZ_o);
      cur.f = first_o;     cur.l = last_o;
      if (done_o) done_cnt++;
      if (have_hold) begin
        n_vec++;
        if (!valid_o || cur != hold) begin
          n_err++;
          $display("FAIL stall_hold: got v=%0d (%0d,%0d,%0d,%0d,%0d) expected v=1 (%0d,%0d,%0d,%0d,%0d)",
                   valid_o, cur.x, cur.y, cur.z, cur.f, cur.l, hold.x, hold.y, hold.z, hold.f, hold.l);
        end
      end
      if (valid_o && ready_i) begin
        have_hold = 1'b0;
        beats_seen++;
        if (last_o) last_cnt++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL beat_unexpected: got (%0d,%0d,%0d,%0d,%0d) expected no beat",
                   cur.x, cur.y, cur.z, cur.f, cur.l);
        end else begin
          expb = exp_q.pop_front();
          if (cur != expb) begin
            n_err++;
            $display("FAIL beat%0d: got (%0d,%0d,%0d,%0d,%0d) expected (%0d,%0d,%0d,%0d,%0d)", beats_seen,
                     cur.x, cur.y, cur.z, cur.f, cur.l, expb.x, expb.y, expb.z, expb.f, expb.l);
          end
        end
      end else if (valid_o) begin
        hold = cur;
        have_hold = 1'b1;
      end
    end
  end

  // reference: the convolution loop nest written directly
  task automatic model(input int sx, input int sy);
    beat_t b;
    int    lo, hi;
    if (sx == 0 || sy == 0) return;
    for (int i = 0; i <= sx + sy - 2; i++) begin
      lo = (i - sy + 1 > 0) ? i - sy + 1 : 0;
      hi = (i < sx - 1) ? i : sx - 1;
      for (int j = lo; j <= hi; j++) begin
        b.x = 8'(j); b.y = 8'(i - j); b.z = 8'(i);
        b.f = (j == lo); b.l = (j == hi);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic issue_start(input int sx, input int sy);
    @(posedge clk_i); #1;
    start_i = 1'b1;
    sizeX_i = (AX + 1)'(sx);
    sizeY_i = (AY + 1)'(sy);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    sizeX_i = (AX + 1)'($urandom);
    sizeY_i = (AY + 1)'($urandom);
  endtask

  task automatic run_job(input int sx, input int sy, input int mode, input bit mid_start);
    int d0, b0, l0, cyc;
    bit empty;
    empty = (sx == 0 || sy == 0);
    d0 = done_cnt; b0 = beats_seen; l0 = last_cnt;
    rdy_mode = mode; phase = 0;
    model(sx, sy);
    issue_start(sx, sy);
    chk("busy_after_start", int'(busy_o), 1);
    chk("valid_after_start", int'(valid_o), empty ? 0 : 1);
    if (empty) chk("done_immediate", int'(done_o), 1);
    cyc = 0;
    while (!done_o && cyc < 5000) begin
      start_i = (mid_start && cyc == 100);
      @(posedge clk_i); #1;
      cyc++;
    end
    start_i = 1'b0;
    chk("done_reached", int'(done_o), 1);
    chk("valid_at_done", int'(valid_o), 0);
    chk("beat_count", beats_seen - b0, sx * sy);
    chk("queue_drained", exp_q.size(), 0);
    chk("last_count", last_cnt - l0, empty ? 0 : sx + sy - 1);
    exp_q.delete();
    // start coincident with done must be dropped
    start_i = 1'b1;
    sizeX_i = 6'd2; sizeY_i = 6'd2;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("idle_after_done_busy", int'(busy_o), 0);
    chk("idle_after_done_valid", int'(valid_o), 0);
    @(posedge clk_i); #1;
    chk("done_pulses", done_cnt - d0, 1);
    chk("still_idle", int'(busy_o), 0);
  endtask

  task automatic reset_job();
    int d0, b0, cyc;
    d0 = done_cnt; b0 = beats_seen;
    rdy_mode = 0;
    model(3, 2);
    issue_start(3, 2);
    cyc = 0;
    while (beats_seen - b0 < 2 && cyc < 50) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    chk("reset_job_progress", (beats_seen - b0 >= 2) ? 1 : 0, 1);
    @(negedge clk_i); #2;
    rst_n_i = 1'b0;
    #1;
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_addr", int'(addrX_o) + int'(addrY_o) + int'(addrZ_o), 0);
    chk("rst_flags", int'(first_o) + int'(last_o), 0);
    exp_q.delete();
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_idle", int'(busy_o), 0);
  endtask

  initial begin
    #1;
    chk("reset_valid", int'(valid_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_done", int'(done_o), 0);
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    run_job(3, 2, 0, 1'b0);
    run_job(3, 2, 1, 1'b0);
    run_job(1, 1, 0, 1'b0);
    run_job(0, 5, 0, 1'b0);
    run_job(5, 0, 2, 1'b0);
    run_job(32, 32, 0, 1'b1);
    reset_job();
    run_job(3, 2, 0, 1'b0);
    for (int k = 0; k < 8; k++)
      run_job(int'($urandom_range(0, 12)), int'($urandom_range(0, 12)), int'($urandom_range(0, 2)), 1'b0);
    run_job(32, 1, 2, 1'b0);
    run_job(1, 32, 1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
